v_fu_clkgate_ctrl: RTL and testbench
====================================

Name: v_fu_clkgate_ctrl

Overview:
Parametrised clock-gating and issue sequencer for the vector coprocessor's functional units (reduction, ALU, multiplier, slide, load/store, and future units).
- Replaces the combinational "op != 0" clock enables with registered, glitch-free enables that drive the BUFGCE CE pins.
- Adds a wake-up delay, a per-unit linger window, start/done handshakes, a writeback-valid strobe, timeout detection and a ready/valid issue interface toward the decoder.
- One operation is in flight at a time.

Parameters:
NUM_FU, 5, number of gated functional units (index 0=red, 1=alu, 2=mul, 3=sldu, 4=lsu).
WAKE_CYC, 2, cycles the clock enable is high before fu_start for a cold unit (min 1).
HOLD_CYC, 1, cycles the clock stays on after done, before returning to IDLE (0 allowed).
LINGER_CYC, 4, cycles a unit's clock stays enabled after HOLD, allowing warm re-issue (0 = gate immediately).
TIMEOUT_CYC, 64, max RUN cycles before abort (0 = timeout disabled).

Ports:
clk  in  1  core clock
nrst  in  1  asynchronous active-low reset
instr_valid  in  1  decoder has an operation
instr_ready  out  1  controller can accept an operation
fu_sel  in  NUM_FU  one-hot target unit; sampled on handshake
fu_done  in  NUM_FU  per-unit done
fu_clk_en  out  NUM_FU  registered BUFGCE CE per unit
fu_start  out  NUM_FU  one-cycle start pulse
wb_valid  out  1  one-cycle writeback strobe
wb_fu_idx  out  $clog2(NUM_FU)  unit that completed
busy  out  1  state != IDLE
sel_err  out  1  one-cycle pulse on illegal fu_sel
timeout_err  out  1  sticky timeout flag
err_clr  in  1  clears timeout_err

Behaviour:
- Reset (async, nrst=0): state=IDLE; all counters 0; all outputs 0 except instr_ready=1. Reset mid-operation aborts immediately, with no wb_valid.
- FSM states: IDLE, WAKE, RUN, HOLD. instr_ready=1 only in IDLE.
- Handshake at cycle 0 (instr_valid & instr_ready):
  - fu_sel zero or multi-hot: sel_err=1 at cycle 1; stay in IDLE; no clock enable or start.
  - Target unit i warm (fu_clk_en[i]=1 from linger): RUN at cycle 1, fu_start[i]=1 at cycle 1.
  - Target unit cold: fu_clk_en[i]=1 from cycle 1; WAKE for cycles 1..WAKE_CYC; RUN with fu_start[i] at cycle WAKE_CYC+1.
- RUN:
  - Only fu_done[i] of the active unit is observed, starting the cycle after fu_start. Done of other units and done outside RUN are ignored.
  - fu_done[i] at cycle D: wb_valid=1 and wb_fu_idx=i at D+1; HOLD for cycles D+1..D+HOLD_CYC; IDLE at D+HOLD_CYC+1. With HOLD_CYC=0, IDLE is entered at D+1 together with wb_valid.
- Timeout: a RUN cycle counter increments each RUN cycle. When it reaches TIMEOUT_CYC without done: timeout_err=1, go to IDLE, no wb_valid, unit i enters linger.
  - err_clr clears timeout_err. If err_clr and a new timeout coincide, set wins.
- fu_clk_en[i]:
  - High during WAKE/RUN/HOLD for the active unit.
  - After leaving HOLD (or timeout), stays high for LINGER_CYC cycles via a per-unit down-counter, then drops.
  - Re-issue to the same unit during linger reloads nothing; the unit is owned by the FSM again.
  - Linger counters of other units keep decrementing independently.
  - All fu_clk_en bits are flop outputs; no combinational path from any input.
- Counter widths: $clog2(max+1) of the respective parameter. No wrap; the RUN counter saturates.

Optional Feature:
V_CG_STATS_EN
- Defined: per-unit 32-bit saturating counters of fu_clk_en-high cycles. Added ports stat_sel (in, $clog2(NUM_FU)) and stat_cnt (out, 32, registered, 1-cycle latency). Counters are cleared by reset only.
- Undefined: no counters and no stat ports.

Decomposition:
- v_pkg holds typedef fu_state_e {IDLE,WAKE,RUN,HOLD}, localparam FU_RED/FU_ALU/FU_MUL/FU_SLDU/FU_LSU indices, and a onehot-to-index function.
- Sub-module v_fu_linger: a per-unit linger down-counter plus clk_en flop, instantiated NUM_FU times with a generate loop.

Test Plan:
1. Reset with defaults -> instr_ready=1, fu_clk_en=0, busy=0. Issue fu_sel=5'b00010 at cycle 0 -> fu_clk_en[1]=1 at cycle 1, fu_start[1] at cycle 3. fu_done[1] at cycle 6 -> wb_valid, wb_fu_idx=1 at cycle 7; IDLE at cycle 8; fu_clk_en[1] drops at cycle 12.
2. Re-issue to unit 1 at cycle 9 (warm) -> fu_start[1] at cycle 10, no WAKE; clk_en continuous.
3. fu_sel=5'b00110 -> sel_err pulse at cycle 1, no fu_start, instr_ready stays 1.
4. Unit 2 never signals done -> timeout_err=1 after 64 RUN cycles, no wb_valid, IDLE. err_clr -> flag cleared.
5. nrst low during RUN -> all outputs 0 immediately; after release instr_ready=1, no wb_valid.
6. fu_done[3] asserted while unit 4 is in RUN -> ignored; unit 4's later done yields wb_fu_idx=4.

Source files
------------

// File: rtl/v_pkg.sv
// Shared types for the vector FU clock-gating controller.
// FSM state encoding, unit indices and a one-hot-to-index helper.
package v_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAKE,
        RUN,
        HOLD
    } fu_state_e;

    localparam int FU_RED  = 0;
    localparam int FU_ALU  = 1;
    localparam int FU_MUL  = 2;
    localparam int FU_SLDU = 3;
    localparam int FU_LSU  = 4;

    localparam int MAX_FU = 32;

    function automatic int unsigned oh2idx(input logic [MAX_FU-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_FU; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/v_fu_linger.sv
// Per-unit linger down-counter and registered BUFGCE clock enable.
// The FSM owns the enable while active; afterwards it lingers LINGER_CYC cycles.
module v_fu_linger
    import v_pkg::*;
#(
    parameter int LINGER_CYC = 4
) (
    input  logic clk,
    input  logic nrst,
    input  logic own_nxt,
    input  logic rel,
    output logic clk_en
);

    localparam int LW = (LINGER_CYC > 0) ? $clog2(LINGER_CYC + 1) : 1;

    logic [LW-1:0] cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt    <= '0;
            clk_en <= 1'b0;
        end else if (own_nxt) begin
            cnt    <= '0;
            clk_en <= 1'b1;
        end else if (rel) begin
            cnt    <= LW'(LINGER_CYC);
            clk_en <= (LINGER_CYC != 0);
        end else if (cnt != '0) begin
            cnt    <= cnt - LW'(1);
            clk_en <= (cnt > LW'(1));
        end else begin
            clk_en <= 1'b0;
        end
    end

endmodule

// File: rtl/v_fu_clkgate_ctrl.sv
// Clock-gating and issue sequencer for the vector functional units.
// Optional per-unit enable-cycle statistics under `V_CG_STATS_EN.
module v_fu_clkgate_ctrl
    import v_pkg::*;
#(
    parameter int NUM_FU      = 5,
    parameter int WAKE_CYC    = 2,
    parameter int HOLD_CYC    = 1,
    parameter int LINGER_CYC  = 4,
    parameter int TIMEOUT_CYC = 64,
    localparam int IW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [NUM_FU-1:0] fu_sel,
    input  logic [NUM_FU-1:0] fu_done,
    output logic [NUM_FU-1:0] fu_clk_en,
    output logic [NUM_FU-1:0] fu_start,
    output logic              wb_valid,
    output logic [IW-1:0]     wb_fu_idx,
    output logic              busy,
    output logic              sel_err,
    output logic              timeout_err,
    input  logic              err_clr
`ifdef V_CG_STATS_EN
    ,
    input  logic [IW-1:0]     stat_sel,
    output logic [31:0]       stat_cnt
`endif
);

    localparam int WW = (WAKE_CYC > 0) ? $clog2(WAKE_CYC + 1) : 1;
    localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    fu_state_e         state, state_n;
    logic [NUM_FU-1:0] act, act_n;
    logic [NUM_FU-1:0] start_n, own, own_n;
    logic [WW-1:0]     wcnt, wcnt_n;
    logic [HW-1:0]     hcnt, hcnt_n;
    logic [TW-1:0]     rcnt, rcnt_n, rinc;
    logic [IW-1:0]     idx_n;
    logic              wb_n, serr_n, terr_n, hit;

    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    always_comb begin
        state_n = state;
        act_n   = act;
        wcnt_n  = wcnt;
        hcnt_n  = hcnt;
        rcnt_n  = rcnt;
        start_n = '0;
        wb_n    = 1'b0;
        idx_n   = wb_fu_idx;
        serr_n  = 1'b0;
        hit     = 1'b0;
        rinc    = (rcnt == '1) ? rcnt : rcnt + TW'(1);
        unique case (state)
            IDLE: begin
                if (instr_valid) begin
                    if (!$onehot(fu_sel)) begin
                        serr_n = 1'b1;
                    end else if ((fu_sel & fu_clk_en) != '0) begin
                        act_n   = fu_sel;
                        state_n = RUN;
                        start_n = fu_sel;
                        rcnt_n  = '0;
                    end else begin
                        act_n   = fu_sel;
                        state_n = WAKE;
                        wcnt_n  = WW'(1);
                    end
                end
            end
            WAKE: begin
                if (wcnt >= WW'(WAKE_CYC)) begin
                    state_n = RUN;
                    start_n = act;
                    rcnt_n  = '0;
                end else begin
                    wcnt_n = wcnt + WW'(1);
                end
            end
            RUN: begin
                rcnt_n = rinc;
                // done is ignored in the start cycle itself
                if (fu_start == '0 && (fu_done & act) != '0) begin
                    wb_n  = 1'b1;
                    idx_n = IW'(oh2idx(MAX_FU'(act)));
                    if (HOLD_CYC == 0) begin
                        state_n = IDLE;
                    end else begin
                        state_n = HOLD;
                        hcnt_n  = HW'(1);
                    end
                end else if (TIMEOUT_CYC != 0 && rinc == TW'(TIMEOUT_CYC)) begin
                    hit     = 1'b1;
                    state_n = IDLE;
                end
            end
            HOLD: begin
                if (hcnt >= HW'(HOLD_CYC)) begin
                    state_n = IDLE;
                end else begin
                    hcnt_n = hcnt + HW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        terr_n = hit | (timeout_err & ~err_clr);
    end

    assign own   = act & {NUM_FU{state != IDLE}};
    assign own_n = act_n & {NUM_FU{state_n != IDLE}};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            act         <= '0;
            wcnt        <= '0;
            hcnt        <= '0;
            rcnt        <= '0;
            fu_start    <= '0;
            wb_valid    <= 1'b0;
            wb_fu_idx   <= '0;
            sel_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            act         <= act_n;
            wcnt        <= wcnt_n;
            hcnt        <= hcnt_n;
            rcnt        <= rcnt_n;
            fu_start    <= start_n;
            wb_valid    <= wb_n;
            wb_fu_idx   <= idx_n;
            sel_err     <= serr_n;
            timeout_err <= terr_n;
        end
    end

    for (genvar g = 0; g < NUM_FU; g++) begin : g_lg
        v_fu_linger #(
            .LINGER_CYC(LINGER_CYC)
        ) u_lg (
            .clk    (clk),
            .nrst   (nrst),
            .own_nxt(own_n[g]),
            .rel    (own[g] & ~own_n[g]),
            .clk_en (fu_clk_en[g])
        );
    end

`ifdef V_CG_STATS_EN
    logic [31:0] stat_q [NUM_FU];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_FU; i++) stat_q[i] <= '0;
            stat_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_clk_en[i] && stat_q[i] != '1) stat_q[i] <= stat_q[i] + 32'd1;
            end
            stat_cnt <= (int'(stat_sel) < NUM_FU) ? stat_q[stat_sel] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_v_fu_clkgate_ctrl.sv
// Scoreboard bench for v_fu_clkgate_ctrl: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_v_fu_clkgate_ctrl;
    import v_pkg::*;

    localparam int NF = 5;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          nrst;
    logic          instr_valid;
    logic          instr_ready;
    logic [NF-1:0] fu_sel;
    logic [NF-1:0] fu_done;
    logic [NF-1:0] fu_clk_en;
    logic [NF-1:0] fu_start;
    logic          wb_valid;
    logic [IW-1:0] wb_fu_idx;
    logic          busy;
    logic          sel_err;
    logic          timeout_err;
    logic          err_clr;

    v_fu_clkgate_ctrl dut (
        .clk        (clk),
        .nrst       (nrst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .fu_sel     (fu_sel),
        .fu_done    (fu_done),
        .fu_clk_en  (fu_clk_en),
        .fu_start   (fu_start),
        .wb_valid   (wb_valid),
        .wb_fu_idx  (wb_fu_idx),
        .busy       (busy),
        .sel_err    (sel_err),
        .timeout_err(timeout_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    typedef enum int {K_START, K_WB, K_SERR, K_CLKEN, K_BUSY, K_READY, K_TERR} kind_e;
    typedef struct {
        int    cyc;
        kind_e k;
        int    val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int c, input kind_e k, input int v);
        exp_t e;
        e.cyc = c;
        e.k   = k;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    function automatic int sample(input kind_e k);
        case (k)
            K_START: return int'(fu_start);
            K_WB:    return wb_valid ? 8 + int'(wb_fu_idx) : 0;
            K_SERR:  return int'(sel_err);
            K_CLKEN: return int'(fu_clk_en);
            K_BUSY:  return int'(busy);
            K_READY: return int'(instr_ready);
            default: return int'(timeout_err);
        endcase
    endfunction

    // monitor: compare due expectations, flag unexpected pulses
    always @(negedge clk) begin
        logic [6:0] seen;
        int         got;
        seen = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                got = sample(q[i].k);
                n_cmp++;
                if (got != q[i].val) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d got=%0d exp=%0d", q[i].k.name(), cyc, got, q[i].val);
                end
                seen[int'(q[i].k)] = 1'b1;
                q.delete(i);
            end else if (q[i].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stale_%s cyc=%0d got=none exp=%0d", q[i].k.name(), q[i].cyc, q[i].val);
                q.delete(i);
            end
        end
        if (!seen[int'(K_START)] && fu_start != '0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexp_start cyc=%0d got=%0d exp=0", cyc, int'(fu_start));
        end
        if (!seen[int'(K_WB)] && wb_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexp_wb cyc=%0d got=%0d exp=0", cyc, int'(wb_fu_idx));
        end
        if (!seen[int'(K_SERR)] && sel_err) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexp_sel_err cyc=%0d got=1 exp=0", cyc);
        end
    end

    int t;

    initial begin
        nrst        = 1'b0;
        instr_valid = 1'b0;
        fu_sel      = '0;
        fu_done     = '0;
        err_clr     = 1'b0;
        tick();
        tick();
        chk(cyc, K_READY, 1);
        chk(cyc, K_CLKEN, 0);
        chk(cyc, K_BUSY, 0);
        chk(cyc, K_TERR, 0);
        tick();
        nrst = 1'b1;
        tick();
        tick();

        // cold issue to ALU, done, linger expiry
        t = cyc;
        instr_valid = 1'b1;
        fu_sel      = 5'b00010;
        chk(t, K_CLKEN, 0);
        chk(t + 1, K_CLKEN, 2);
        chk(t + 1, K_BUSY, 1);
        chk(t + 1, K_READY, 0);
        chk(t + 2, K_CLKEN, 2);
        chk(t + 3, K_START, 2);
        tick();
        instr_valid = 1'b0;
        fu_sel      = '0;
        wait_to(t + 6);
        fu_done = 5'b00010;
        chk(t + 7, K_WB, 8 + FU_ALU);
        chk(t + 7, K_BUSY, 1);
        chk(t + 8, K_BUSY, 0);
        chk(t + 8, K_READY, 1);
        chk(t + 8, K_CLKEN, 2);
        chk(t + 11, K_CLKEN, 2);
        chk(t + 12, K_CLKEN, 0);
        tick();
        fu_done = '0;
        wait_to(t + 15);

        // cold issue then warm re-issue during linger
        t = cyc;
        instr_valid = 1'b1;
        fu_sel      = 5'b00010;
        chk(t + 3, K_START, 2);
        tick();
        instr_valid = 1'b0;
        wait_to(t + 6);
        fu_done = 5'b00010;
        chk(t + 7, K_WB, 8 + FU_ALU);
        tick();
        fu_done = '0;
        wait_to(t + 9);
        instr_valid = 1'b1;
        chk(t + 9, K_CLKEN, 2);
        chk(t + 10, K_START, 2);
        chk(t + 10, K_CLKEN, 2);
        chk(t + 10, K_BUSY, 1);
        tick();
        instr_valid = 1'b0;
        wait_to(t + 12);
        fu_done = 5'b00010;
        chk(t + 13, K_WB, 8 + FU_ALU);
        tick();
        fu_done = '0;
        wait_to(t + 22);

        // illegal selects: multi-hot, then zero
        t = cyc;
        instr_valid = 1'b1;
        fu_sel      = 5'b00110;
        chk(t + 1, K_SERR, 1);
        chk(t + 1, K_READY, 1);
        chk(t + 1, K_BUSY, 0);
        chk(t + 1, K_CLKEN, 0);
        tick();
        fu_sel = 5'b00000;
        chk(t + 2, K_SERR, 1);
        chk(t + 2, K_CLKEN, 0);
        tick();
        instr_valid = 1'b0;
        wait_to(t + 5);

        // MUL never finishes: timeout, set beats a coincident clear
        t = cyc;
        instr_valid = 1'b1;
        fu_sel      = 5'b00100;
        chk(t + 3, K_START, 4);
        chk(t + 66, K_BUSY, 1);
        chk(t + 66, K_TERR, 0);
        chk(t + 67, K_TERR, 1);
        chk(t + 67, K_BUSY, 0);
        chk(t + 67, K_CLKEN, 4);
        chk(t + 70, K_CLKEN, 4);
        chk(t + 71, K_CLKEN, 0);
        chk(t + 72, K_TERR, 1);
        chk(t + 73, K_TERR, 0);
        tick();
        instr_valid = 1'b0;
        fu_sel      = '0;
        wait_to(t + 66);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        wait_to(t + 72);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        wait_to(t + 76);

        // reset in the middle of RUN
        t = cyc;
        instr_valid = 1'b1;
        fu_sel      = 5'b00001;
        chk(t + 1, K_CLKEN, 1);
        chk(t + 3, K_START, 1);
        tick();
        instr_valid = 1'b0;
        fu_sel      = '0;
        wait_to(t + 5);
        nrst    = 1'b0;
        fu_done = 5'b00001;
        chk(t + 5, K_CLKEN, 0);
        chk(t + 5, K_BUSY, 0);
        chk(t + 5, K_READY, 1);
        wait_to(t + 7);
        nrst    = 1'b1;
        fu_done = '0;
        chk(t + 8, K_BUSY, 0);
        chk(t + 8, K_READY, 1);
        chk(t + 8, K_CLKEN, 0);
        wait_to(t + 10);

        // foreign done ignored in RUN, done ignored in IDLE
        t = cyc;
        instr_valid = 1'b1;
        fu_sel      = 5'b10000;
        chk(t + 3, K_START, 16);
        tick();
        instr_valid = 1'b0;
        fu_sel      = '0;
        wait_to(t + 5);
        fu_done = 5'b01000;
        chk(t + 7, K_BUSY, 1);
        tick();
        fu_done = '0;
        wait_to(t + 8);
        fu_done = 5'b10000;
        chk(t + 9, K_WB, 8 + FU_LSU);
        chk(t + 9, K_BUSY, 1);
        chk(t + 10, K_BUSY, 0);
        tick();
        fu_done = '0;
        wait_to(t + 11);
        fu_done = 5'b11111;
        chk(t + 12, K_BUSY, 0);
        chk(t + 12, K_CLKEN, 16);
        tick();
        fu_done = '0;

        wait_to(t + 20);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover cyc=%0d got=%0d exp=0", cyc, q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
